imm_extend_pipe: RTL and testbench
==================================

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
- REQ-001 Parameter IN_W, default 16: immediate input width; SHALL be >= 8.
- REQ-002 Parameter OUT_W, default 32: extended output width; SHALL be >= IN_W + 2.
- REQ-003 clk  input  1  sole clock, rising edge; one clock domain.
- REQ-004 reset  input  1  asynchronous, active-high reset.
- REQ-005 in_valid  input  1  in_imm/in_mode valid this cycle.
- REQ-006 in_ready  output  1  block accepts input this cycle.
- REQ-007 in_imm  input  IN_W  immediate to extend.
- REQ-008 in_mode  input  3  extension mode.
- REQ-009 out_valid  output  1  out_data/out_err valid.
- REQ-010 out_ready  input  1  consumer accepts output this cycle.
- REQ-011 out_data  output  OUT_W  extended value.
- REQ-012 out_err  output  1  entry carried a reserved/disabled mode.

Function
- REQ-013 Modes SHALL be: 000 zero-extend; 001 upper (in_imm << (OUT_W-IN_W), low bits 0); 010 sign-extend from in_imm[IN_W-1]; 011 sign-extend then shift left 2 (branch offset, top 2 bits discarded); 100 sign-extend in_imm[7:0]; 101 zero-extend in_imm[7:0]; 110, 111 reserved.
- REQ-014 Reserved or disabled modes SHALL produce out_data = 0 and out_err = 1; all valid modes produce out_err = 0.
- REQ-015 Extension SHALL be computed at accept time and stored with the entry; later changes to in_* SHALL NOT affect a stored entry.
- REQ-016 Transfer in SHALL occur when in_valid && in_ready; transfer out when out_valid && out_ready.
- REQ-017 Storage SHALL be a 2-entry FIFO, count 0..2; out_data/out_err SHALL always present the head entry.
- REQ-018 Latency SHALL be 1 cycle: entry accepted at edge N is visible with out_valid=1 after edge N, i.e. in cycle N+1.
- REQ-019 Sustained throughput SHALL be 1 entry/cycle when out_ready is held high.
- REQ-020 in_ready SHALL equal (count != 2) and SHALL depend only on registered state, with no combinational path from out_ready or in_valid.
- REQ-021 When full and out_ready=1, the pop SHALL complete and in_ready SHALL rise the next cycle, not the same cycle.
- REQ-022 Simultaneous push and pop SHALL leave count unchanged and preserve order.
- REQ-023 Pop when empty and push when full SHALL be impossible by construction; count SHALL never wrap.
- REQ-024 out_valid SHALL equal (count != 0).
- REQ-025 While out_valid=1 and out_ready=0, out_data/out_err SHALL stay stable.

Reset
- REQ-026 Asserting reset SHALL immediately clear count to 0, force out_valid=0, out_data=0, out_err=0, and in_ready=0.
- REQ-027 In-flight entries SHALL be discarded on reset, including mid-stream.
- REQ-028 in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
- REQ-029 Macro IMM_EXT_BYTE_EN defined: modes 100/101 SHALL behave per REQ-013.
- REQ-030 IMM_EXT_BYTE_EN undefined: modes 100/101 SHALL be treated as reserved per REQ-014, and no byte-extension logic is synthesised.

Structure
- REQ-031 Shared package mips_ext_pkg SHALL hold the 3-bit mode encodings (EXM_ZERO, EXM_UPPER, EXM_SIGN, EXM_SIGN_SL2, EXM_BYTE_S, EXM_BYTE_Z) and the default width constants.
- REQ-032 The combinational extension function SHALL live in one sub-module, imm_ext_core, instanced once ahead of the FIFO.

Verification (IN_W=16, OUT_W=32)
- REQ-033 Mode 010 with imm 0x8001 accepted at edge N -> out_data 0xFFFF8001, out_err 0, out_valid in cycle N+1; mode 000 with 0x8001 -> 0x00008001.
- REQ-034 Mode 001 with 0x1234 -> 0x12340000; mode 011 with 0xFFFF -> 0xFFFFFFFC; mode 011 with 0x0004 -> 0x00000010.
- REQ-035 out_ready=0, push 0x0001, 0x0002, 0x0003 -> in_ready low after the 2nd accept, 3rd held; raise out_ready -> outputs 1, 2, 3 in order; in_ready rises the cycle after the first pop.
- REQ-036 Mode 100 with 0x0080: macro defined -> 0xFFFFFF80, err 0; macro undefined -> 0x00000000, err 1. Mode 111 with any imm -> 0, err 1.
- REQ-037 With 2 entries stored, pulse reset mid-cycle -> out_valid and in_ready drop without a clock edge; after release count is 0 and in_ready is 1.
- REQ-038 out_ready=1 with back-to-back valid inputs for 100 cycles -> 100 outputs in 101 cycles, with no bubbles.

Source files
------------

// File: rtl/mips_ext_pkg.sv
// Shared immediate-extension mode encodings and default widths.
package mips_ext_pkg;

  localparam int DEF_IN_W  = 16;
  localparam int DEF_OUT_W = 32;

  localparam logic [2:0] EXM_ZERO     = 3'b000;
  localparam logic [2:0] EXM_UPPER    = 3'b001;
  localparam logic [2:0] EXM_SIGN     = 3'b010;
  localparam logic [2:0] EXM_SIGN_SL2 = 3'b011;
  localparam logic [2:0] EXM_BYTE_S   = 3'b100;
  localparam logic [2:0] EXM_BYTE_Z   = 3'b101;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender; 0 cycles. Byte modes 100/101 exist only with IMM_EXT_BYTE_EN,
// otherwise they fall into the reserved path (data 0, err 1).
module imm_ext_core
  import mips_ext_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic [IN_W-1:0]  i_imm,
  input  logic [2:0]       i_mode,
  output logic [OUT_W-1:0] o_data,
  output logic             o_err
);

  logic [OUT_W-1:0] w_sext;

  assign w_sext = {{(OUT_W-IN_W){i_imm[IN_W-1]}}, i_imm};

  always_comb begin
    o_data = '0;
    o_err  = 1'b0;
    case (i_mode)
      EXM_ZERO:     o_data = {{(OUT_W-IN_W){1'b0}}, i_imm};
      EXM_UPPER:    o_data = {i_imm, {(OUT_W-IN_W){1'b0}}};
      EXM_SIGN:     o_data = w_sext;
      EXM_SIGN_SL2: o_data = w_sext << 2;
`ifdef IMM_EXT_BYTE_EN
      EXM_BYTE_S:   o_data = {{(OUT_W-8){i_imm[7]}}, i_imm[7:0]};
      EXM_BYTE_Z:   o_data = {{(OUT_W-8){1'b0}}, i_imm[7:0]};
`endif
      default:      o_err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate extender feeding a 2-entry FIFO; 1-cycle latency, 1 entry/cycle, in_ready from registered count only.
// Optional byte modes enabled by IMM_EXT_BYTE_EN (see imm_ext_core).
module imm_extend_pipe
  import mips_ext_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err
);

  logic [OUT_W-1:0] w_ext_data;
  logic             w_ext_err;
  logic             w_push;
  logic             w_pop;

  logic [OUT_W-1:0] r_data [2];
  logic [1:0]       r_err;
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .i_imm  (in_imm),
    .i_mode (in_mode),
    .o_data (w_ext_data),
    .o_err  (w_ext_err)
  );

  // Reset gates in_ready directly so it drops without waiting for a clock edge.
  assign in_ready  = ~reset & (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign out_data  = out_valid ? r_data[r_rptr] : '0;
  assign out_err   = out_valid ? r_err[r_rptr]  : 1'b0;

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data[0] <= '0;
      r_data[1] <= '0;
      r_err     <= '0;
      r_wptr    <= 1'b0;
      r_rptr    <= 1'b0;
      r_count   <= 2'd0;
    end else begin
      if (w_push) begin
        r_data[r_wptr] <= w_ext_data;
        r_err[r_wptr]  <= w_ext_err;
        r_wptr         <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Randomised and directed bench for imm_extend_pipe against a queue-based arithmetic model.
module tb_imm_extend_pipe;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_imm = '0;
  logic [2:0]  in_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;
  ent_t q[$];

  imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Arithmetic reference: work in 64-bit signed integers, then keep the low 32 bits.
  function automatic ent_t model(input logic [15:0] imm, input logic [2:0] mode);
    ent_t   r;
    longint z, s, zb, sb, v;
    z  = longint'(imm);
    s  = imm[15] ? z - 65536 : z;
    zb = longint'(imm & 16'h00FF);
    sb = (zb >= 128) ? zb - 256 : zb;
    v  = 0;
    r.e = 1'b0;
    case (mode)
      3'd0: v = z;
      3'd1: v = z * 65536;
      3'd2: v = s;
      3'd3: v = s * 4;
`ifdef IMM_EXT_BYTE_EN
      3'd4: v = sb;
      3'd5: v = zb;
`endif
      default: begin v = 0; r.e = 1'b1; end
    endcase
    r.d = v[31:0];
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
    end else begin
      automatic bit push = in_valid && (q.size() != 2);
      automatic bit pop  = out_ready && (q.size() != 0);
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(model(in_imm, in_mode));
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
    end else begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
      chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() != 2});
      if (q.size() != 0) begin
        chk("out_data", out_data, q[0].d);
        chk("out_err", {31'd0, out_err}, {31'd0, q[0].e});
        if (out_ready) n_pops++;
      end
    end
  end

  task automatic send(input logic [15:0] imm, input logic [2:0] mode);
    bit rdy;
    int n;
    in_imm = imm; in_mode = mode; in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 50);
    if (!rdy) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic directed(input string nm, input logic [15:0] imm, input logic [2:0] mode,
                          input logic [31:0] exp_d, input logic exp_e);
    ent_t m;
    out_ready = 1'b1;
    m = model(imm, mode);
    chk({"model_", nm}, m.d, exp_d);
    send(imm, mode);
    @(negedge clk);
    chk({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({nm, "_data"}, out_data, exp_d);
    chk({nm, "_err"}, {31'd0, out_err}, {31'd0, exp_e});
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    #9 reset = 1'b0;
    #1 chk("first_rdy", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    directed("sign_8001",  16'h8001, 3'd2, 32'hFFFF8001, 1'b0);
    directed("zero_8001",  16'h8001, 3'd0, 32'h00008001, 1'b0);
    directed("upper_1234", 16'h1234, 3'd1, 32'h12340000, 1'b0);
    directed("sl2_ffff",   16'hFFFF, 3'd3, 32'hFFFFFFFC, 1'b0);
    directed("sl2_0004",   16'h0004, 3'd3, 32'h00000010, 1'b0);
`ifdef IMM_EXT_BYTE_EN
    directed("byte_s_0080", 16'h0080, 3'd4, 32'hFFFFFF80, 1'b0);
    directed("byte_z_0080", 16'h0080, 3'd5, 32'h00000080, 1'b0);
`else
    directed("byte_s_0080", 16'h0080, 3'd4, 32'h00000000, 1'b1);
    directed("byte_z_0080", 16'h0080, 3'd5, 32'h00000000, 1'b1);
`endif
    directed("rsv_111", 16'hBEEF, 3'd7, 32'h00000000, 1'b1);
    directed("rsv_110", 16'h1234, 3'd6, 32'h00000000, 1'b1);

    // Backpressure: fill, hold a third, then drain in order.
    out_ready = 1'b0;
    send(16'h0001, 3'd0);
    send(16'h0002, 3'd0);
    @(negedge clk);
    chk("full_rdy_low", {31'd0, in_ready}, 32'd0);
    in_imm = 16'h0003; in_mode = 3'd0; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("held_rdy_low", {31'd0, in_ready}, 32'd0);
      chk("held_head", out_data, 32'd1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("pop_same_cycle_rdy", {31'd0, in_ready}, 32'd0);
    chk("drain_1", out_data, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rdy_after_pop", {31'd0, in_ready}, 32'd1);
    chk("drain_2", out_data, 32'd2);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("drain_3", out_data, 32'd3);
    @(posedge clk); #1;

    // Mid-cycle reset with two entries stored.
    out_ready = 1'b0;
    send(16'h0005, 3'd0);
    send(16'h0006, 3'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst_out_data", out_data, 32'd0);
    chk("midrst_out_err", {31'd0, out_err}, 32'd0);
    #1 reset = 1'b0;
    #1 chk("post_rst_rdy", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    chk("post_rst_empty", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;

    // Throughput: 100 back-to-back inputs with out_ready high.
    out_ready = 1'b1;
    n_pops = 0;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_imm   = 16'($urandom);
      in_mode  = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("thru_pops", n_pops, 32'd100);
    chk("thru_empty", {31'd0, out_valid}, 32'd0);

    // Random traffic with a mid-stream reset.
    for (int i = 0; i < 600; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_imm    = 16'($urandom);
      in_mode   = 3'($urandom_range(0, 7));
      if (i == 300) begin
        #3 reset = 1'b1;
        #1 reset = 1'b0;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("final_empty", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
